mobius_seq_anf2tt: RTL and testbench
====================================

// Module: mobius_seq_anf2tt
// PURPOSE
//   Sequential inverse Mobius engine: converts an N-coefficient ANF vector into its N-point truth table.
//   Over GF(2) the transform is an involution, so this block uses the same butterfly as the combinational forward transform.
//   Data is loaded as W-bit words over a valid/ready stream, and the register file is transformed one butterfly stage per cycle.
//   The result is streamed out on a second valid/ready port.
//   Used where a full N*log2(N) XOR array is too large, and as the decoder paired with the ANF-producing transform.
// PARAMETERS
//   N       2048  vector length; power of two, >= 2
//   LOG2_N  11    log2(N); must match N
//   W       32    stream word width; power of two, W <= N, N % W == 0
// PORTS
//   clk        in   1  single clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   in_valid   in   1  input word valid
//   in_ready   out  1  engine accepts an input word (LOAD state only)
//   in_data    in   W  [0:W-1]; word k carries coefficients k*W+j = in_data[j]
//   out_valid  out  1  output word valid (DRAIN state only)
//   out_ready  in   1  downstream accepts the word
//   out_data   out  W  [0:W-1]; word k carries truth-table bits k*W+j = out_data[j]
//   out_last   out  1  high with the final word (k = N/W-1)
//   busy       out  1  high in COMPUTE and DRAIN
// BEHAVIOUR
//   - States: LOAD -> COMPUTE -> DRAIN -> LOAD. Word counter wc is log2(N/W) bits; stage counter sc is ceil(log2(LOG2_N+1)) bits.
//   - Reset (async, while rst = 1):
//       state = LOAD, wc = 0, sc = 0; vector register x is not cleared.
//       in_ready = 0 while rst is high, 1 from the first clock after release.
//       out_valid = 0, out_last = 0, busy = 0, out_data = 0.
//   - LOAD:
//       in_ready = 1. On in_valid & in_ready, x[wc*W +: W] <= in_data and wc increments.
//       Acceptance of word N/W-1 moves to COMPUTE next cycle, with wc wrapped to 0.
//   - COMPUTE:
//       in_ready = 0. Cycle s (s = 0..LOG2_N-1) applies stage s with h = N >> (s+1):
//       for every i with floor(i/h) odd, x[i] <= x[i] ^ x[i-h]. All other x[i] hold.
//       After stage LOG2_N-1, state goes to DRAIN.
//       Latency: LOG2_N cycles from last input handshake to first out_valid.
//   - DRAIN:
//       out_valid = 1, out_data = x[wc*W +: W]; advance wc only on out_valid & out_ready.
//       out_data/out_valid stay stable while out_ready = 0.
//       Final handshake (out_last = 1) returns to LOAD with wc = 0. in_ready rises on the next cycle; no load/drain overlap.
//   - in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.
//   - A reset in any state aborts the frame immediately: partial load or partial drain is discarded.
//   - Throughput: one frame per 2*(N/W) + LOG2_N cycles at zero stalls.
// CONFIGURATION
//   STAGE_PAIR_EN defined:
//       COMPUTE applies stages 2t and 2t+1 in one cycle (cascaded XOR), t = 0..ceil(LOG2_N/2)-1.
//       For odd LOG2_N, the final cycle applies one stage. Latency becomes ceil(LOG2_N/2) cycles (6 at default).
//   STAGE_PAIR_EN undefined:
//       One stage per cycle, latency LOG2_N. Port behaviour is otherwise identical.
// TESTING
//   1. ANF = only coeff 0 set (in word 0: in_data[0] = 1, all other bits 0)
//      -> all 64 output words all-ones, out_last on word 63.
//   2. ANF = only coeff N-1 set (word 63, in_data[W-1] = 1)
//      -> words 0..62 zero; word 63 has only out_data[W-1] = 1.
//   3. Random 2048-bit vector loaded, output looped back in as a second frame
//      -> second output equals original vector (involution); first frame matches a software model.
//   4. out_ready toggled 1,0,0,1 and in_valid gapped randomly
//      -> no word dropped or duplicated; out_data stable during stalls; first out_valid exactly LOG2_N
//         (or 6 with STAGE_PAIR_EN) cycles after last input handshake.
//   5. rst pulsed mid-COMPUTE (stage 5) and mid-DRAIN (word 10)
//      -> out_valid/busy drop asynchronously; in_ready = 1 one cycle after release; next frame correct.
//   6. Small build N=16, LOG2_N=4, W=4, ANF = coeffs {1,2} set (x0 ^ x1 form)
//      -> truth-table bits equal ((i>>0)&1) ^ ((i>>1)&1) per model, over 4 output words.

Source files
------------

// File: rtl/mobius_seq_anf2tt.sv
// mobius_seq_anf2tt: sequential inverse Mobius (ANF -> truth table) engine.
// Loads N bits as N/W words, runs one butterfly stage per cycle over the
// vector register, then streams the truth table back out as N/W words.
// Optional macro STAGE_PAIR_EN: two cascaded stages per COMPUTE cycle.
module mobius_seq_anf2tt #(
   parameter int N      = 2048,
   parameter int LOG2_N = 11,
   parameter int W      = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int NW  = N / W;
   localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
   localparam int SCW = $clog2(LOG2_N + 1);
`ifdef STAGE_PAIR_EN
   localparam int SC_END = (LOG2_N + 1) / 2 - 1;
`else
   localparam int SC_END = LOG2_N - 1;
`endif
   localparam logic [WCW-1:0] WC_LAST = WCW'(NW - 1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(SC_END);

   // Row k marks the upper half of every butterfly block of stage k,
   // i.e. the bits i with floor(i/h) odd, h = N >> (k+1).
   function automatic logic [LOG2_N-1:0][N-1:0] masks_f();
      logic [LOG2_N-1:0][N-1:0] m;
      for (int k = 0; k < LOG2_N; k++)
         for (int i = 0; i < N; i++)
            m[k][i] = ((i >> (LOG2_N - 1 - k)) & 1) != 0;
      return m;
   endfunction

   localparam logic [LOG2_N-1:0][N-1:0] MASKS = masks_f();

   // One butterfly stage: x[i] ^= x[i-h] on the masked half. A stage index
   // past LOG2_N-1 is a no-op, which covers the odd tail of paired mode.
   function automatic logic [N-1:0] stage_apply(input logic [N-1:0] v, input int s);
      logic [N-1:0] r;
      r = v;
      for (int k = 0; k < LOG2_N; k++)
         if (k == s) r = v ^ ((v << (N >> (k + 1))) & MASKS[k]);
      return r;
   endfunction

   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

   state_t         state;
   logic [WCW-1:0] wc;
   logic [SCW-1:0] sc;
   logic [N-1:0]   x;
   logic [N-1:0]   xn;

   // Next vector value for the current COMPUTE cycle.
   always_comb begin
      xn = x;
`ifdef STAGE_PAIR_EN
      xn = stage_apply(x, 2 * int'(sc));
      xn = stage_apply(xn, 2 * int'(sc) + 1);
`else
      xn = stage_apply(x, int'(sc));
`endif
   end

   // Vector register: filled word by word in LOAD, transformed in COMPUTE.
   // Deliberately not reset; a reset only discards the frame via control.
   always_ff @(posedge clk) begin
      if (state == S_LOAD && in_valid && in_ready)
         x[int'(wc)*W +: W] <= in_data;
      else if (state == S_COMPUTE)
         x <= xn;
   end

   // Frame control FSM with registered handshake and output signals.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_LOAD;
         wc        <= '0;
         sc        <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (!in_ready)
                  in_ready <= 1'b1;
               else if (in_valid) begin
                  if (wc == WC_LAST) begin
                     wc       <= '0;
                     state    <= S_COMPUTE;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                  end else
                     wc <= wc + 1'b1;
               end
            end
            S_COMPUTE: begin
               if (sc == SC_LAST) begin
                  sc        <= '0;
                  state     <= S_DRAIN;
                  out_valid <= 1'b1;
                  out_data  <= xn[W-1:0];
                  out_last  <= (NW == 1);
               end else
                  sc <= sc + 1'b1;
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= S_LOAD;
                     wc        <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                  end else begin
                     wc       <= wc + 1'b1;
                     out_data <= x[(int'(wc) + 1)*W +: W];
                     out_last <= ((wc + 1'b1) == WC_LAST);
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_mobius_seq_anf2tt.sv
// Scoreboard bench for mobius_seq_anf2tt: default build plus a 16-point build.
module tb_mobius_seq_anf2tt;

   localparam int N      = 2048;
   localparam int LOG2_N = 11;
   localparam int W      = 32;
   localparam int NW     = N / W;
`ifdef STAGE_PAIR_EN
   localparam int EXP_LAT = (LOG2_N + 1) / 2;
`else
   localparam int EXP_LAT = LOG2_N;
`endif

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic [W-1:0] in_data, out_data;

   logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy;
   logic [3:0] s_in_data, s_out_data;

   always #5 clk = ~clk;

   mobius_seq_anf2tt #(.N(N), .LOG2_N(LOG2_N), .W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy));

   mobius_seq_anf2tt #(.N(16), .LOG2_N(4), .W(4)) dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy));

   typedef struct packed { logic [W-1:0] d; logic last; } exp_t;
   exp_t       exp_q[$];
   logic [4:0] sq[$];

   int errs = 0, chks = 0, pops = 0, cyc = 0, hs_cyc = 0, rmode = 0;
   bit lat_arm = 0, stall_prev = 0;
   logic [W-1:0] prev_data;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference transform written as subset sums over each index bit.
   function automatic logic [N-1:0] mobius(input logic [N-1:0] v);
      logic [N-1:0] t;
      t = v;
      for (int b = 0; b < LOG2_N; b++)
         for (int i = 0; i < N; i++)
            if (((i >> b) & 1) != 0) t[i] = t[i] ^ t[i - (1 << b)];
      return t;
   endfunction

   function automatic logic [N-1:0] rand_vec();
      logic [N-1:0] r;
      for (int k = 0; k < NW; k++) r[k*W +: W] = $urandom;
      return r;
   endfunction

   task automatic push_vec(input logic [N-1:0] e);
      for (int k = 0; k < NW; k++) exp_q.push_back({e[k*W +: W], k == NW - 1});
   endtask

   task automatic send_frame(input logic [N-1:0] v, input bit gaps);
      for (int k = 0; k < NW; k++) begin
         bit ok;
         if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_data  = v[k*W +: W];
         ok = 0;
         for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
         end
         if (!ok) check("in_ready_timeout", 0, 1);
         if (k == NW - 1) begin hs_cyc = cyc + 1; lat_arm = 1; end
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 5000 && (exp_q.size() != 0 || sq.size() != 0); i++) @(posedge clk);
      check("drain_done", 64'(exp_q.size() + sq.size()), 0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      exp_q.delete();
      lat_arm = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rel_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1 check("rel_in_ready_high", in_ready, 1);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: always on, or the repeating 1,0,0,1 pattern.
   initial begin
      int k = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 out_ready = (rmode == 0) ? 1'b1 : ((k % 4 == 1 || k % 4 == 2) ? 1'b0 : 1'b1);
         k++;
      end
   end

   // Monitor: stall stability, latency, and scoreboard pops.
   always @(negedge clk) begin
      exp_t e;
      if (rst) stall_prev = 0;
      else begin
         if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
         end
         if (lat_arm && out_valid) begin
            check("latency", 64'(cyc - hs_cyc), 64'(EXP_LAT));
            lat_arm = 0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_word", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("out_data", out_data, e.d);
               check("out_last", out_last, e.last);
            end
            pops++;
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // Monitor for the 16-point build.
   always @(negedge clk) begin
      logic [4:0] se;
      if (!rst && s_out_valid && s_out_ready) begin
         if (sq.size() == 0) check("s_unexpected_word", 1, 0);
         else begin
            se = sq.pop_front();
            check("s_out_data", s_out_data, se[3:0]);
            check("s_out_last", s_out_last, se[4]);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] v1, v2, r, e;
      int base;
      bit ok;
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
      #1;
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_last", out_last, 0);
      check("reset_busy", busy, 0);
      check("reset_out_data", 64'(out_data), 0);
      #20;
      @(negedge clk) rst = 1'b0;
      #1 check("rel_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1 check("rel_in_ready_high", in_ready, 1);

      // Only coefficient 0: constant-one function.
      v1 = '0; v1[0] = 1'b1;
      for (int k = 0; k < NW; k++) exp_q.push_back({32'hFFFF_FFFF, k == NW - 1});
      send_frame(v1, 0);
      wait_empty();

      // Only coefficient N-1: single minterm at the top index.
      v2 = '0; v2[N-1] = 1'b1;
      for (int k = 0; k < NW; k++)
         exp_q.push_back({(k == NW - 1) ? 32'h8000_0000 : 32'h0, k == NW - 1});
      send_frame(v2, 0);
      wait_empty();

      // Random frame, then its output looped back must restore the input.
      r = rand_vec();
      e = mobius(r);
      push_vec(e);
      send_frame(r, 0);
      wait_empty();
      push_vec(r);
      send_frame(e, 0);
      wait_empty();

      // Output stalls 1,0,0,1 with gapped input.
      rmode = 1;
      r = rand_vec();
      push_vec(mobius(r));
      send_frame(r, 1);
      wait_empty();
      rmode = 0;

      // Reset during COMPUTE stage 5, then a clean frame.
      for (int k = 0; k < NW; k++) exp_q.push_back({32'hFFFF_FFFF, k == NW - 1});
      send_frame(v1, 0);
      repeat (5) @(posedge clk);
      #2 check("busy_in_compute", busy, 1);
      apply_reset();
      for (int k = 0; k < NW; k++) exp_q.push_back({32'hFFFF_FFFF, k == NW - 1});
      send_frame(v1, 0);
      wait_empty();

      // Reset during DRAIN around word 10, then a clean frame.
      base = pops;
      for (int k = 0; k < NW; k++)
         exp_q.push_back({(k == NW - 1) ? 32'h8000_0000 : 32'h0, k == NW - 1});
      send_frame(v2, 0);
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(posedge clk);
         ok = (pops >= base + 10);
      end
      if (!ok) check("drain_word10_timeout", 0, 1);
      #2 check("busy_in_drain", busy, 1);
      apply_reset();
      for (int k = 0; k < NW; k++)
         exp_q.push_back({(k == NW - 1) ? 32'h8000_0000 : 32'h0, k == NW - 1});
      send_frame(v2, 0);
      wait_empty();

      // 16-point build: coefficients {1,2} give x0 ^ x1, pattern 0,1,1,0.
      for (int k = 0; k < 4; k++) sq.push_back({k == 3, 4'b0110});
      for (int k = 0; k < 4; k++) begin
         #1;
         s_in_valid = 1'b1;
         s_in_data  = (k == 0) ? 4'b0110 : 4'b0000;
         ok = 0;
         for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = s_in_ready;
         end
         if (!ok) check("s_in_ready_timeout", 0, 1);
         @(posedge clk);
         #1 s_in_valid = 1'b0;
      end
      wait_empty();

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
